// File: rtl/icc_branch_unit.sv
// SPARC V8 icc register, Bicc condition evaluation and delay-slot/annul FSM.
// Optional ICC_FORWARD_EN: Bicc evaluates against same-cycle cc writes.
module icc_branch_unit #(
  parameter logic [3:0] ICC_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_inst_valid,
  input  logic       i_is_alu,
  input  logic [5:0] i_alu_op,
  input  logic       i_alu_n,
  input  logic       i_alu_z,
  input  logic       i_alu_v,
  input  logic       i_alu_c,
  input  logic       i_wr_icc,
  input  logic [3:0] i_psr_icc_in,
  input  logic       i_is_bicc,
  input  logic [3:0] i_cond,
  input  logic       i_annul,
  output logic [3:0] o_icc,
  output logic       o_br_taken,
  output logic       o_squash,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StDslot   = 2'b01,
    StAnnul   = 2'b10,
    StIllegal = 2'b11
  } state_e;

  state_e     r_state;
  state_e     w_state_d;
  logic [3:0] r_icc;
  logic       r_br_taken;
  logic       r_squash;

  logic       w_live;
  logic       w_cc_set;
  logic [3:0] w_alu_flags;
  logic [3:0] w_eval_cc;
  logic       w_taken;
  logic       w_annul_br;
  logic       w_bicc_live;

  // cond[3] complements the base test; cond 8 falls out as ~never = always.
  function automatic logic f_cond_taken(input logic [3:0] cond, input logic [3:0] cc);
    logic n, z, v, c, t;
    n = cc[3];
    z = cc[2];
    v = cc[1];
    c = cc[0];
    unique case (cond[2:0])
      3'd0:    t = 1'b0;
      3'd1:    t = z;
      3'd2:    t = z | (n ^ v);
      3'd3:    t = n ^ v;
      3'd4:    t = c | z;
      3'd5:    t = c;
      3'd6:    t = n;
      default: t = v;
    endcase
    return cond[3] ? ~t : t;
  endfunction

  assign w_live      = i_inst_valid && (r_state != StAnnul);
  assign w_cc_set    = i_is_alu && (i_alu_op[5:4] == 2'b01) &&
                       ((i_alu_op[3:0] <= 4'd8) || (i_alu_op[3:0] == 4'd12));
  assign w_alu_flags = {i_alu_n, i_alu_z, i_alu_v, i_alu_c};

`ifdef ICC_FORWARD_EN
  assign w_eval_cc = i_wr_icc ? i_psr_icc_in : (w_cc_set ? w_alu_flags : r_icc);
`else
  assign w_eval_cc = r_icc;
`endif

  assign w_taken     = f_cond_taken(i_cond, w_eval_cc);
  assign w_annul_br  = i_annul && (!w_taken || (i_cond == 4'd8));
  // The illegal state only recovers to IDLE; a Bicc seen there does not redirect.
  assign w_bicc_live = w_live && i_is_bicc && (r_state != StIllegal);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StDslot: begin
        if (i_inst_valid) begin
          if (i_is_bicc) w_state_d = w_annul_br ? StAnnul : StDslot;
          else           w_state_d = StIdle;
        end
      end
      StAnnul: begin
        if (i_inst_valid) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_icc      <= ICC_RESET;
      r_state    <= StIdle;
      r_br_taken <= 1'b0;
      r_squash   <= 1'b0;
    end else begin
      if (w_live && i_wr_icc)      r_icc <= i_psr_icc_in;
      else if (w_live && w_cc_set) r_icc <= w_alu_flags;
      r_br_taken <= w_bicc_live && w_taken;
      r_state    <= w_state_d;
      r_squash   <= (w_state_d == StAnnul);
    end
  end

  assign o_icc      = r_icc;
  assign o_br_taken = r_br_taken;
  assign o_squash   = r_squash;
  assign o_state    = r_state;

endmodule

// File: tb/tb_icc_branch_unit.sv
// Directed self-checking bench for icc_branch_unit.
module tb_icc_branch_unit;

  logic       clk;
  logic       rst_n;
  logic       inst_valid;
  logic       is_alu;
  logic [5:0] alu_op;
  logic       alu_n, alu_z, alu_v, alu_c;
  logic       wr_icc;
  logic [3:0] psr_icc_in;
  logic       is_bicc;
  logic [3:0] cond;
  logic       annul;
  logic [3:0] icc;
  logic       br_taken;
  logic       squash;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  icc_branch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_inst_valid (inst_valid),
    .i_is_alu     (is_alu),
    .i_alu_op     (alu_op),
    .i_alu_n      (alu_n),
    .i_alu_z      (alu_z),
    .i_alu_v      (alu_v),
    .i_alu_c      (alu_c),
    .i_wr_icc     (wr_icc),
    .i_psr_icc_in (psr_icc_in),
    .i_is_bicc    (is_bicc),
    .i_cond       (cond),
    .i_annul      (annul),
    .o_icc        (icc),
    .o_br_taken   (br_taken),
    .o_squash     (squash),
    .o_state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    inst_valid = 1'b0;
    is_alu     = 1'b0;
    alu_op     = 6'd0;
    {alu_n, alu_z, alu_v, alu_c} = 4'b0000;
    wr_icc     = 1'b0;
    psr_icc_in = 4'b0000;
    is_bicc    = 1'b0;
    cond       = 4'd0;
    annul      = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic issue_nop();
    clear_inputs();
    inst_valid = 1'b1;
    step();
  endtask

  task automatic issue_wrpsr(input logic [3:0] v);
    clear_inputs();
    inst_valid = 1'b1;
    wr_icc     = 1'b1;
    psr_icc_in = v;
    step();
  endtask

  task automatic issue_alu(input logic [5:0] op, input logic [3:0] f);
    clear_inputs();
    inst_valid = 1'b1;
    is_alu     = 1'b1;
    alu_op     = op;
    {alu_n, alu_z, alu_v, alu_c} = f;
    step();
  endtask

  task automatic issue_bicc(input logic [3:0] c, input logic a);
    clear_inputs();
    inst_valid = 1'b1;
    is_bicc    = 1'b1;
    cond       = c;
    annul      = a;
    step();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (icc !== 4'b0000 || state !== 2'b00 || squash !== 1'b0 || br_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: icc=%b state=%b squash=%b br=%b, want 0000 00 0 0",
               icc, state, squash, br_taken);
    end
    #10 rst_n = 1'b1;
  endtask

  task automatic test_cc_write();
    issue_alu(6'b010100, 4'b0101);
    checks++;
    if (icc !== 4'b0101) begin
      errors++; $display("FAIL subcc_write: icc=%b want 0101", icc);
    end
    issue_alu(6'b000100, 4'b1010);
    checks++;
    if (icc !== 4'b0101) begin
      errors++; $display("FAIL sub_no_s: icc=%b want 0101", icc);
    end
    issue_alu(6'b011100, 4'b1001);
    checks++;
    if (icc !== 4'b1001) begin
      errors++; $display("FAIL op12_write: icc=%b want 1001", icc);
    end
    issue_alu(6'b011001, 4'b0110);
    checks++;
    if (icc !== 4'b1001) begin
      errors++; $display("FAIL op9_nowrite: icc=%b want 1001", icc);
    end
    clear_inputs();
    inst_valid = 1'b1;
    is_alu     = 1'b1;
    alu_op     = 6'b010000;
    {alu_n, alu_z, alu_v, alu_c} = 4'b1100;
    wr_icc     = 1'b1;
    psr_icc_in = 4'b0011;
    step();
    checks++;
    if (icc !== 4'b0011) begin
      errors++; $display("FAIL wr_icc_wins: icc=%b want 0011", icc);
    end
  endtask

  task automatic test_branch();
    issue_wrpsr(4'b0100);
    issue_bicc(4'd1, 1'b1);
    checks++;
    if (br_taken !== 1'b1 || state !== 2'b01 || squash !== 1'b0) begin
      errors++;
      $display("FAIL be_taken: br=%b state=%b squash=%b want 1 01 0", br_taken, state, squash);
    end
    issue_nop();
    checks++;
    if (br_taken !== 1'b0 || state !== 2'b00) begin
      errors++; $display("FAIL dslot_exit: br=%b state=%b want 0 00", br_taken, state);
    end
    issue_bicc(4'd9, 1'b1);
    checks++;
    if (br_taken !== 1'b0 || state !== 2'b10 || squash !== 1'b1) begin
      errors++;
      $display("FAIL bne_annul: br=%b state=%b squash=%b want 0 10 1", br_taken, state, squash);
    end
    issue_nop();
    checks++;
    if (state !== 2'b00 || squash !== 1'b0) begin
      errors++; $display("FAIL annul_exit: state=%b squash=%b want 00 0", state, squash);
    end
  endtask

  task automatic test_ba_annul();
    issue_bicc(4'd8, 1'b1);
    checks++;
    if (br_taken !== 1'b1 || squash !== 1'b1 || state !== 2'b10) begin
      errors++;
      $display("FAIL ba_annul: br=%b squash=%b state=%b want 1 1 10", br_taken, squash, state);
    end
    issue_alu(6'b010000, 4'b1000);
    checks++;
    if (icc !== 4'b0100 || state !== 2'b00 || br_taken !== 1'b0) begin
      errors++;
      $display("FAIL squashed_addcc: icc=%b state=%b br=%b want 0100 00 0", icc, state, br_taken);
    end
    // A Bicc in the annulled slot must be ignored.
    issue_bicc(4'd8, 1'b1);
    issue_bicc(4'd8, 1'b0);
    checks++;
    if (br_taken !== 1'b0 || state !== 2'b00) begin
      errors++; $display("FAIL squashed_bicc: br=%b state=%b want 0 00", br_taken, state);
    end
  endtask

  task automatic test_stall();
    issue_bicc(4'd1, 1'b0);
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (state !== 2'b01 || br_taken !== 1'b0 || icc !== 4'b0100) begin
      errors++;
      $display("FAIL stall_hold: state=%b br=%b icc=%b want 01 0 0100", state, br_taken, icc);
    end
    issue_nop();
    checks++;
    if (state !== 2'b00) begin
      errors++; $display("FAIL stall_exit: state=%b want 00", state);
    end
  endtask

  task automatic test_dcti();
    issue_bicc(4'd1, 1'b0);
    issue_bicc(4'd9, 1'b1);
    checks++;
    if (state !== 2'b10 || br_taken !== 1'b0 || squash !== 1'b1) begin
      errors++;
      $display("FAIL dcti_couple: state=%b br=%b squash=%b want 10 0 1", state, br_taken, squash);
    end
    issue_nop();
  endtask

  task automatic test_cond_table();
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    exp_a = 16'hE916;
    exp_b = 16'h3FC0;
    issue_wrpsr(4'b0100);
    for (int c = 0; c < 16; c++) begin
      issue_bicc(c[3:0], 1'b0);
      checks++;
      if (br_taken !== exp_a[c]) begin
        errors++; $display("FAIL cond_z c=%0d: br=%b want %b", c, br_taken, exp_a[c]);
      end
      issue_nop();
    end
    issue_wrpsr(4'b1010);
    for (int c = 0; c < 16; c++) begin
      issue_bicc(c[3:0], 1'b0);
      checks++;
      if (br_taken !== exp_b[c]) begin
        errors++; $display("FAIL cond_nv c=%0d: br=%b want %b", c, br_taken, exp_b[c]);
      end
      issue_nop();
    end
  endtask

  task automatic test_forward();
    logic exp_br;
`ifdef ICC_FORWARD_EN
    exp_br = 1'b1;
`else
    exp_br = 1'b0;
`endif
    issue_wrpsr(4'b0000);
    clear_inputs();
    inst_valid = 1'b1;
    is_alu     = 1'b1;
    alu_op     = 6'b010000;
    {alu_n, alu_z, alu_v, alu_c} = 4'b0100;
    is_bicc    = 1'b1;
    cond       = 4'd1;
    step();
    checks++;
    if (br_taken !== exp_br || icc !== 4'b0100) begin
      errors++;
      $display("FAIL same_cycle: br=%b icc=%b want %b 0100", br_taken, icc, exp_br);
    end
    issue_nop();
  endtask

  task automatic test_reset_mid_annul();
    issue_wrpsr(4'b0101);
    issue_bicc(4'd9, 1'b1);
    checks++;
    if (state !== 2'b10) begin
      errors++; $display("FAIL pre_reset_annul: state=%b want 10", state);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (icc !== 4'b0000 || state !== 2'b00 || squash !== 1'b0 || br_taken !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: icc=%b state=%b squash=%b br=%b want 0000 00 0 0",
               icc, state, squash, br_taken);
    end
    #2 rst_n = 1'b1;
    issue_nop();
    checks++;
    if (state !== 2'b00 || squash !== 1'b0) begin
      errors++; $display("FAIL post_reset: state=%b squash=%b want 00 0", state, squash);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    step();
    test_cc_write();
    test_branch();
    test_ba_annul();
    test_stall();
    test_dcti();
    test_cond_table();
    test_forward();
    test_reset_mid_annul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icc_branch_unit.md
Name: icc_branch_unit

Overview:
- Consumer end of the ALU's N/Z/V/C flag outputs.
- Holds the SPARC V8 integer condition codes (icc), updating them on cc-setting ALU ops (S bit set) and on WRPSR.
- Evaluates the 16 Bicc conditions against icc.
- Runs the delay-slot/annul state machine that tells the fetch/issue stage to redirect the PC and whether to squash the delay-slot instruction.

Parameters:
ICC_RESET, 4'b0000, reset value of {N,Z,V,C}

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
inst_valid  input  1  an instruction issues this cycle; low = stall, all state holds
is_alu  input  1  issuing instruction is an ALU op
alu_op  input  6  ALU opcode of the issuing instruction (same encoding as ALU op input)
alu_n, alu_z, alu_v, alu_c  input  1 each  flags from the ALU for this instruction
wr_icc  input  1  issuing instruction is WRPSR
psr_icc_in  input  4  {N,Z,V,C} written by WRPSR
is_bicc  input  1  issuing instruction is Bicc
cond  input  4  Bicc cond field
annul  input  1  Bicc a bit
icc  output  4  registered {N,Z,V,C}
br_taken  output  1  registered one-cycle pulse: branch accepted the previous cycle was taken
squash  output  1  high while the next issuing instruction must be annulled
state  output  2  FSM state, for debug

Behaviour:
Reset:
- Asynchronous on rst_n low.
- icc = ICC_RESET; state = IDLE (2'b00); br_taken = 0; squash = 0.
- Reset mid-branch drops any pending annul.

Accept:
- An instruction is accepted when inst_valid=1.
- It is live when accepted and state != ANNUL.
- Only live instructions affect icc or the FSM.

cc write:
- Live, is_alu=1 and alu_op matches 6'b01xxxx with op[3:0] in {0..8, 12}: icc <= {alu_n, alu_z, alu_v, alu_c} at the next edge.
- Any other alu_op (S=0, shifts, undefined) leaves icc unchanged.
- Live wr_icc=1: icc <= psr_icc_in.
- If wr_icc and a cc-setting ALU op are both flagged, wr_icc wins.

Condition evaluation uses the registered icc (value before this cycle's update). Taken by cond:
- 0 never
- 1 Z
- 2 Z|(N^V)
- 3 N^V
- 4 C|Z
- 5 C
- 6 N
- 7 V
- 8 always
- 9-15: complement of cond-8 respectively

Annul condition: annul=1 AND (not taken OR cond==8).

FSM (Moore; squash = (state==ANNUL)):
- IDLE (00): live Bicc -> ANNUL if annul condition, else DSLOT. Other live instructions stay in IDLE.
- DSLOT (01): next accepted instruction is the delay slot and executes normally. If it is itself a Bicc (DCTI couple), evaluate it as in IDLE; otherwise -> IDLE.
- ANNUL (10): next accepted instruction is squashed: no icc write, any Bicc ignored, br_taken not raised. Then -> IDLE.
- 11: illegal; -> IDLE next edge, outputs as IDLE.

br_taken:
- Registered: set at the edge after a live Bicc evaluates taken, cleared the following edge unless another taken Bicc is accepted.
- Independent of annul.

Stalls: inst_valid=0 holds icc, state, squash; br_taken clears.

Latency: icc visible 1 cycle after accept; br_taken/squash 1 cycle after the Bicc is accepted.

Optional Feature:
- Macro: ICC_FORWARD_EN.
- Defined: a Bicc uses a same-cycle cc value. This value is psr_icc_in if wr_icc, else the ALU flags if a cc-setting ALU op is flagged, else icc. It serves split-issue/fused pipelines where the flag-setting op and the branch are presented together.
- Undefined: registered icc only, as above.

Test Plan:
- Reset: rst_n=0 mid-ANNUL -> icc=4'b0000, state=00, squash=0 immediately without clock.
- SUBcc alu_op=6'b010100 with flags {0,1,0,1} -> icc=4'b0101 next cycle. Same flags with alu_op=6'b000100 -> icc unchanged.
- icc=4'b0100; BE (cond=1, annul=1) -> br_taken=1, state=DSLOT, squash=0. BNE annul=1 -> br_taken=0, state=ANNUL, squash=1.
- BA annul=1 -> br_taken=1, squash=1. The following ADDcc with flags 4'b1000 is squashed: icc unchanged, state -> IDLE.
- Stall: BE taken, then inst_valid=0 for 3 cycles -> state stays DSLOT. The delay-slot instruction issues -> IDLE.
- Same cycle: ADDcc (flags 4'b0100) + BE on icc=0. Without ICC_FORWARD_EN -> not taken. With it -> taken.
